ip_line_stack: RTL and testbench



---
 rtl/ip_line_stack.sv | 276 +++++++++++++++++++++++++++
 tb/tb_ip_line_stack.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ip_line_stack.sv
// ip_line_stack
// Instruction-pointer line with a loop-return stack. Fetches instructions from
// program ROM and holds the current one for the executor. It resolves `[` / `]`
// branches either by jumping through a stack of loop heads or by scanning the
// ROM for the matching bracket.
//
// Ports
//   Clk, Rst_n      : clock (rising edge) and synchronous active-low reset
//   HaltRq          : halt request, honoured in IDLE with priority over Request
//   DataIsZeroed    : current data cell is zero, sampled when Request is accepted
//   Request         : 1-cycle pulse asking for the next instruction
//   Ready           : IDLE and no Request pending
//   Insn, IpAddress : current instruction and its BCD address
//   LoopDepth       : BCD nesting depth while scanning for a matching bracket
//   RomRequest      : 1-cycle fetch pulse for IpAddress
//   RomReady/RomData: ROM response; RomReady is ignored while RomRequest=1
//   StackOvf, Error : sticky overflow / error flags
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | Insn valid, waiting for Request or HaltRq
// WAIT_ROM | fetch outstanding; scan_q/dir_bwd_q qualify bracket scans
// HALT     | held while HaltRq=1
// ERROR    | unmatched bracket or depth overflow, terminal until reset
module ip_line_stack #(
  parameter int IP_DIGITS   = 5,
  parameter int LOOP_DIGITS = 3,
  parameter int STACK_DEPTH = 8,
  parameter int OVF_WIDTH   = 8,
  parameter int INSN_WIDTH  = 4,
  parameter logic [INSN_WIDTH-1:0] OP_OPEN  = 4'h6,
  parameter logic [INSN_WIDTH-1:0] OP_CLOSE = 4'h7
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     HaltRq,
  input  logic                     DataIsZeroed,
  input  logic                     Request,
  output logic                     Ready,
  output logic [INSN_WIDTH-1:0]    Insn,
  output logic [4*IP_DIGITS-1:0]   IpAddress,
  output logic [4*LOOP_DIGITS-1:0] LoopDepth,
  output logic                     RomRequest,
  input  logic                     RomReady,
  input  logic [INSN_WIDTH-1:0]    RomData,
  output logic                     StackOvf,
  output logic                     Error
);

  localparam int IPW = 4 * IP_DIGITS;
  localparam int DW  = 4 * LOOP_DIGITS;
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam logic [DW-1:0] DEPTH_MAX = {LOOP_DIGITS{4'h9}};

  typedef enum logic [1:0] {S_IDLE, S_WAIT_ROM, S_HALT, S_ERROR} state_t;

  state_t                state_q, state_d;
  logic                  scan_q, scan_d;
  logic                  dir_bwd_q, dir_bwd_d;
  logic                  primed_q, primed_d;
  logic                  rom_req_q, rom_req_d;
  logic                  sovf_q, sovf_d;
  logic [IPW-1:0]        ip_q, ip_d;
  logic [INSN_WIDTH-1:0] insn_q, insn_d;
  logic [DW-1:0]         depth_q, depth_d;
  logic [OVF_WIDTH-1:0]  ovf_q, ovf_d;
  logic [SPW-1:0]        sp_q, sp_d;
  logic [IPW-1:0]        stack_q [STACK_DEPTH];
  logic [IPW-1:0]        stack_d [STACK_DEPTH];

  logic [IPW-1:0] tos;
  logic [DW-1:0]  depth_next;
  logic           stk_full, stk_empty, ovf_zero;
  logic           dep_inc, dep_dec;

  function automatic logic [IPW-1:0] ip_step(input logic [IPW-1:0] v, input logic down);
    logic [IPW-1:0] r;
    logic [3:0]     dg;
    logic           c;
    r = v;
    c = 1'b1;
    for (int k = 0; k < IP_DIGITS; k++) begin
      dg = v[4*k +: 4];
      if (c) begin
        if (down) begin
          if (dg == 4'd0) dg = 4'd9;
          else begin dg = dg - 4'd1; c = 1'b0; end
        end else begin
          if (dg == 4'd9) dg = 4'd0;
          else begin dg = dg + 4'd1; c = 1'b0; end
        end
      end
      r[4*k +: 4] = dg;
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] depth_step(input logic [DW-1:0] v, input logic down);
    logic [DW-1:0] r;
    logic [3:0]    dg;
    logic          c;
    r = v;
    c = 1'b1;
    for (int k = 0; k < LOOP_DIGITS; k++) begin
      dg = v[4*k +: 4];
      if (c) begin
        if (down) begin
          if (dg == 4'd0) dg = 4'd9;
          else begin dg = dg - 4'd1; c = 1'b0; end
        end else begin
          if (dg == 4'd9) dg = 4'd0;
          else begin dg = dg + 4'd1; c = 1'b0; end
        end
      end
      r[4*k +: 4] = dg;
    end
    return r;
  endfunction

  always_comb begin
    tos = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (SPW'(i) == sp_q - SPW'(1)) tos = stack_q[i];
    end
  end

  assign stk_full  = (sp_q == SPW'(STACK_DEPTH));
  assign stk_empty = (sp_q == '0);
  assign ovf_zero  = (ovf_q == '0);

  // Nesting grows on brackets facing away from the scan direction.
  assign dep_inc = dir_bwd_q ? (RomData == OP_CLOSE) : (RomData == OP_OPEN);
  assign dep_dec = dir_bwd_q ? (RomData == OP_OPEN)  : (RomData == OP_CLOSE);

  always_comb begin
    state_d   = state_q;
    scan_d    = scan_q;
    dir_bwd_d = dir_bwd_q;
    primed_d  = primed_q;
    rom_req_d = 1'b0;
    sovf_d    = sovf_q;
    ip_d      = ip_q;
    insn_d    = insn_q;
    depth_d   = depth_q;
    ovf_d     = ovf_q;
    sp_d      = sp_q;
    stack_d   = stack_q;
    depth_next = depth_q;

    unique case (state_q)
      S_IDLE: begin
        if (HaltRq) begin
          state_d = S_HALT;
        end else if (Request) begin
          state_d   = S_WAIT_ROM;
          rom_req_d = 1'b1;
          if (!primed_q) begin
            primed_d = 1'b1;
          end else begin
            ip_d = ip_step(ip_q, 1'b0);
            if (insn_q == OP_OPEN) begin
              if (DataIsZeroed) begin
                scan_d    = 1'b1;
                dir_bwd_d = 1'b0;
                depth_d   = DW'(1);
              end else if (stk_full || !ovf_zero) begin
                // Once overflowed, deeper loops are only counted so pops stay paired.
                if (ovf_q != '1) ovf_d = ovf_q + OVF_WIDTH'(1);
                sovf_d = 1'b1;
              end else begin
                for (int i = 0; i < STACK_DEPTH; i++) begin
                  if (SPW'(i) == sp_q) stack_d[i] = ip_q;
                end
                sp_d = sp_q + SPW'(1);
              end
            end else if (insn_q == OP_CLOSE) begin
              if (DataIsZeroed) begin
                if (!ovf_zero) ovf_d = ovf_q - OVF_WIDTH'(1);
                else if (!stk_empty) sp_d = sp_q - SPW'(1);
              end else if (!stk_empty && ovf_zero) begin
                ip_d = ip_step(tos, 1'b0);
              end else if (ip_q == '0) begin
                state_d   = S_ERROR;
                rom_req_d = 1'b0;
                ip_d      = ip_q;
              end else begin
                scan_d    = 1'b1;
                dir_bwd_d = 1'b1;
                depth_d   = DW'(1);
                ip_d      = ip_step(ip_q, 1'b1);
              end
            end
          end
        end
      end

      S_WAIT_ROM: begin
        if (!rom_req_q && RomReady) begin
          if (!scan_q) begin
            insn_d  = RomData;
            state_d = S_IDLE;
          end else if (dep_inc && depth_q == DEPTH_MAX) begin
            state_d = S_ERROR;
          end else begin
            if (dep_inc)      depth_next = depth_step(depth_q, 1'b0);
            else if (dep_dec) depth_next = depth_step(depth_q, 1'b1);
            depth_d = depth_next;
            if (depth_next == '0) begin
              // Matching bracket found: resume just past it in either direction.
              scan_d    = 1'b0;
              ip_d      = ip_step(ip_q, 1'b0);
              rom_req_d = 1'b1;
            end else if (dir_bwd_q) begin
              if (ip_q == '0) begin
                state_d = S_ERROR;
              end else begin
                ip_d      = ip_step(ip_q, 1'b1);
                rom_req_d = 1'b1;
              end
            end else begin
              ip_d      = ip_step(ip_q, 1'b0);
              rom_req_d = 1'b1;
            end
          end
        end
      end

      S_HALT: begin
        if (!HaltRq) state_d = S_IDLE;
      end

      default: begin
        state_d = S_ERROR;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q   <= S_IDLE;
      scan_q    <= 1'b0;
      dir_bwd_q <= 1'b0;
      primed_q  <= 1'b0;
      rom_req_q <= 1'b0;
      sovf_q    <= 1'b0;
      ip_q      <= '0;
      insn_q    <= '0;
      depth_q   <= '0;
      ovf_q     <= '0;
      sp_q      <= '0;
      stack_q   <= '{default: '0};
    end else begin
      state_q   <= state_d;
      scan_q    <= scan_d;
      dir_bwd_q <= dir_bwd_d;
      primed_q  <= primed_d;
      rom_req_q <= rom_req_d;
      sovf_q    <= sovf_d;
      ip_q      <= ip_d;
      insn_q    <= insn_d;
      depth_q   <= depth_d;
      ovf_q     <= ovf_d;
      sp_q      <= sp_d;
      stack_q   <= stack_d;
    end
  end

  assign Ready      = (state_q == S_IDLE) & ~Request;
  assign Insn       = insn_q;
  assign IpAddress  = ip_q;
  assign LoopDepth  = depth_q;
  assign RomRequest = rom_req_q;
  assign StackOvf   = sovf_q;
  assign Error      = (state_q == S_ERROR);

endmodule

// File: tb/tb_ip_line_stack.sv
// Bench for ip_line_stack: directed scenarios plus random bracket-balanced
// programs, checked against a behavioural model through a response scoreboard.
module tb_ip_line_stack;

  localparam int SD  = 2;
  localparam int MEM = 64;

  logic        Clk = 1'b0;
  logic        Rst_n, HaltRq, DataIsZeroed, Request;
  logic        Ready, RomRequest, RomReady, StackOvf, Error;
  logic [3:0]  Insn, RomData;
  logic [19:0] IpAddress;
  logic [11:0] LoopDepth;

  logic [3:0] mem [MEM];
  int         ip_i;
  bit         rom_fast;

  int checks = 0;
  int errors = 0;

  typedef struct {int ip; int insn; int peak; bit sovf; bit err;} exp_t;
  exp_t sb[$];

  int  m_ip, m_insn, m_ovf;
  int  m_stk[$];
  bit  m_primed, m_sovf, m_err;

  ip_line_stack #(.STACK_DEPTH(SD)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .HaltRq(HaltRq), .DataIsZeroed(DataIsZeroed),
    .Request(Request), .Ready(Ready), .Insn(Insn), .IpAddress(IpAddress),
    .LoopDepth(LoopDepth), .RomRequest(RomRequest), .RomReady(RomReady),
    .RomData(RomData), .StackOvf(StackOvf), .Error(Error)
  );

  always #5 Clk = ~Clk;

  function automatic int from_bcd(input logic [19:0] b, input int nd);
    int r = 0;
    for (int k = nd - 1; k >= 0; k--) r = r * 10 + int'(b[4*k +: 4]);
    return r;
  endfunction

  function automatic logic [19:0] to_bcd5(input int v);
    logic [19:0] r;
    int t = v;
    for (int k = 0; k < 5; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  assign ip_i    = from_bcd(IpAddress, 5);
  assign RomData = (ip_i < MEM) ? mem[ip_i] : 4'h0;

  initial forever begin
    @(posedge Clk);
    #1 RomReady = rom_fast ? 1'b1 : 1'($urandom_range(0, 1));
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int rom(input int a);
    if (a >= 0 && a < MEM) return int'(mem[a]);
    return 0;
  endfunction

  function automatic int inc(input int a);
    return (a + 1) % 100000;
  endfunction

  task automatic model_reset();
    m_ip = 0; m_insn = 0; m_ovf = 0; m_stk.delete();
    m_primed = 0; m_sovf = 0; m_err = 0;
  endtask

  task automatic push_exp(input int pk);
    exp_t e;
    e.ip = m_ip; e.insn = m_insn; e.peak = pk; e.sovf = m_sovf; e.err = m_err;
    sb.push_back(e);
  endtask

  task automatic model_req(input bit z);
    int op, d, pk, guard, o;
    bit busy;
    pk = 0;
    if (!m_primed) begin
      m_primed = 1;
      m_insn = rom(m_ip);
    end else begin
      op = m_insn;
      if (op == 6 && !z) begin
        if (m_stk.size() >= SD || m_ovf > 0) begin
          if (m_ovf < 255) m_ovf++;
          m_sovf = 1;
        end else m_stk.push_back(m_ip);
        m_ip = inc(m_ip);
      end else if (op == 6) begin
        d = 1; pk = 1; guard = 0;
        m_ip = inc(m_ip);
        while (d != 0 && guard < 1000) begin
          o = rom(m_ip);
          if (o == 6) d++;
          else if (o == 7) d--;
          if (d > pk) pk = d;
          m_ip = inc(m_ip);
          guard++;
        end
      end else if (op == 7 && z) begin
        if (m_ovf > 0) m_ovf--;
        else if (m_stk.size() > 0) void'(m_stk.pop_back());
        m_ip = inc(m_ip);
      end else if (op == 7 && m_stk.size() > 0 && m_ovf == 0) begin
        m_ip = inc(m_stk[$]);
      end else if (op == 7) begin
        if (m_ip == 0) m_err = 1;
        else begin
          d = 1; pk = 1; busy = 1;
          m_ip--;
          while (busy) begin
            o = rom(m_ip);
            if (o == 7) d++;
            else if (o == 6) d--;
            if (d > pk) pk = d;
            if (d == 0) begin m_ip = inc(m_ip); busy = 0; end
            else if (m_ip == 0) begin m_err = 1; busy = 0; end
            else m_ip--;
          end
        end
      end else begin
        m_ip = inc(m_ip);
      end
      if (!m_err) m_insn = rom(m_ip);
    end
    push_exp(pk);
  endtask

  // ---------------- monitor ----------------
  initial begin
    bit   prev_rdy, prev_err;
    int   peak, d;
    exp_t e;
    prev_rdy = 1; prev_err = 0; peak = 0;
    forever begin
      @(negedge Clk);
      if (Rst_n !== 1'b1) begin
        prev_rdy = 1; prev_err = 0; peak = 0;
      end else begin
        d = from_bcd({8'h0, LoopDepth}, 3);
        if (d > peak) peak = d;
        if ((Ready && !prev_rdy) || (Error && !prev_err)) begin
          if (sb.size() == 0) chk("unexpected_response", 1, 0);
          else begin
            e = sb.pop_front();
            chk("ip", 32'(IpAddress), 32'(to_bcd5(e.ip)));
            chk("insn", 32'(Insn), 32'(e.insn));
            chk("depth_peak", 32'(peak), 32'(e.peak));
            chk("stack_ovf", 32'(StackOvf), 32'(e.sovf));
            chk("error", 32'(Error), 32'(e.err));
          end
          peak = 0;
        end
        prev_rdy = Ready;
        prev_err = Error;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic wait_ready();
    int n = 0;
    while (Ready !== 1'b1 && n < 2000) begin
      @(posedge Clk); #1;
      n++;
    end
    if (n >= 2000) begin
      checks++; errors++;
      $display("FAIL ready_timeout actual=0 required=1");
    end
  endtask

  task automatic issue_req(input bit z, input bit tchk);
    wait_ready();
    @(posedge Clk); #1;
    Request = 1'b1; DataIsZeroed = z;
    model_req(z);
    @(posedge Clk); #1;
    Request = 1'b0;
    if (tchk) begin
      chk("t1_romreq", 32'(RomRequest), 1);
      chk("t1_ready", 32'(Ready), 0);
      @(posedge Clk); #1;
      chk("t2_romreq", 32'(RomRequest), 0);
      chk("t2_ready", 32'(Ready), 0);
      @(posedge Clk); #1;
      chk("t3_ready", 32'(Ready), 1);
    end
  endtask

  task automatic do_halt(input int k);
    wait_ready();
    @(posedge Clk); #1;
    HaltRq = 1'b1;
    push_exp(0);
    repeat (k) begin
      @(posedge Clk); #1;
      chk("halt_ready", 32'(Ready), 0);
    end
    HaltRq = 1'b0;
    chk("halt_release_ready", 32'(Ready), 0);
    @(posedge Clk); #1;
    chk("halt_after_ready", 32'(Ready), 1);
    chk("halt_ip", 32'(IpAddress), 32'(to_bcd5(m_ip)));
  endtask

  task automatic do_reset();
    @(posedge Clk); #1;
    Rst_n = 1'b0;
    sb.delete();
    repeat (2) @(posedge Clk);
    #1 Rst_n = 1'b1;
    model_reset();
  endtask

  task automatic load(input logic [3:0] p [], input int n);
    for (int i = 0; i < MEM; i++) mem[i] = (i < n) ? p[i] : 4'h0;
  endtask

  task automatic gen_program();
    int len, open, r;
    len = $urandom_range(8, 28);
    open = 0;
    for (int i = 0; i < MEM; i++) mem[i] = 4'h0;
    for (int i = 0; i < len; i++) begin
      r = $urandom_range(0, 99);
      if (len - i == open) begin mem[i] = 4'h7; open--; end
      else if (open > 0 && r < 25) begin mem[i] = 4'h7; open--; end
      else if (r >= 70 && len - i > open + 1) begin mem[i] = 4'h6; open++; end
      else mem[i] = 4'($urandom_range(0, 2));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] p [];
    Rst_n = 1'b0; HaltRq = 1'b0; DataIsZeroed = 1'b0; Request = 1'b0;
    rom_fast = 1'b0; RomReady = 1'b0;
    for (int i = 0; i < MEM; i++) mem[i] = 4'h0;
    model_reset();
    do_reset();

    chk("rst_ip", 32'(IpAddress), 0);
    chk("rst_insn", 32'(Insn), 0);
    chk("rst_depth", 32'(LoopDepth), 0);
    chk("rst_romreq", 32'(RomRequest), 0);
    chk("rst_ovf", 32'(StackOvf), 0);
    chk("rst_err", 32'(Error), 0);

    // prime and step, zero-wait ROM latency
    p = '{4'h1, 4'h1, 4'h0};
    load(p, 3);
    rom_fast = 1'b1;
    issue_req(1'b0, 1'b1);
    issue_req(1'b0, 1'b1);
    wait_ready();

    // stack jump then pop
    rom_fast = 1'b0;
    do_reset();
    p = '{4'h6, 4'h1, 4'h7};
    load(p, 3);
    for (int i = 0; i < 4; i++) issue_req(1'b0, 1'b0);
    issue_req(1'b0, 1'b0);
    issue_req(1'b1, 1'b0);
    wait_ready();

    // forward skip
    do_reset();
    p = '{4'h6, 4'h6, 4'h1, 4'h7, 4'h7, 4'h2};
    load(p, 6);
    issue_req(1'b0, 1'b0);
    issue_req(1'b1, 1'b0);
    wait_ready();

    // overflow with a 2-entry stack, then backward scan of the inner loop
    do_reset();
    p = '{4'h6, 4'h6, 4'h6, 4'h1, 4'h7, 4'h7, 4'h7};
    load(p, 7);
    for (int i = 0; i < 6; i++) issue_req(1'b0, 1'b0);
    wait_ready();
    chk("ovf_sticky", 32'(StackOvf), 1);

    // halt preserves state
    do_halt(3);

    // unmatched close at IP 0
    do_reset();
    p = '{4'h7};
    load(p, 1);
    issue_req(1'b0, 1'b0);
    wait_ready();
    @(posedge Clk); #1;
    Request = 1'b1; DataIsZeroed = 1'b0;
    model_req(1'b0);
    @(posedge Clk); #1;
    Request = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    chk("err_flag", 32'(Error), 1);
    chk("err_ready", 32'(Ready), 0);
    Request = 1'b1;
    @(posedge Clk); #1;
    Request = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("err_terminal", 32'(Error), 1);
    chk("err_romreq", 32'(RomRequest), 0);

    // reset during a forward scan
    do_reset();
    for (int i = 0; i < MEM; i++) mem[i] = 4'h0;
    for (int i = 0; i < 4; i++) mem[i] = 4'h6;
    for (int i = 4; i < 24; i++) mem[i] = 4'h1;
    for (int i = 24; i < 28; i++) mem[i] = 4'h7;
    rom_fast = 1'b1;
    for (int i = 0; i < 4; i++) issue_req(1'b0, 1'b0);
    issue_req(1'b1, 1'b0);
    repeat (12) @(posedge Clk);
    #1;
    chk("midscan_active", 32'(LoopDepth != 12'h0), 1);
    chk("midscan_ovf", 32'(StackOvf), 1);
    Rst_n = 1'b0;
    sb.delete();
    @(posedge Clk); #1;
    chk("midrst_ip", 32'(IpAddress), 0);
    chk("midrst_depth", 32'(LoopDepth), 0);
    chk("midrst_romreq", 32'(RomRequest), 0);
    chk("midrst_ovf", 32'(StackOvf), 0);
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    model_reset();
    rom_fast = 1'b0;

    // random balanced programs
    for (int prog = 0; prog < 6; prog++) begin
      do_reset();
      gen_program();
      for (int n = 0; n < 25; n++) begin
        if (m_primed && $urandom_range(0, 99) < 12) do_halt($urandom_range(1, 3));
        else issue_req(1'($urandom_range(0, 1)), 1'b0);
      end
      wait_ready();
      repeat (3) @(posedge Clk);
    end

    repeat (5) @(posedge Clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
